// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: FSM state encoding,
// source numbering, register offsets and the vector address helper.
package irq_pkg;

  // Request handshake states; the encoding is visible to software in IVEC.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_t;

  // Interrupt sources, lowest number has the highest priority.
  localparam int unsigned SRC_KBD   = 0;
  localparam int unsigned SRC_TMR   = 1;
  localparam int unsigned SRC_VSYNC = 2;
  localparam int unsigned SRC_SPARE = 3;
  localparam int unsigned NUM_SRC   = SRC_SPARE + 1;

  // Port offsets from the block base address.
  localparam logic [15:0] OFS_IMASK = 16'd0;
  localparam logic [15:0] OFS_IPEND = 16'd1;
  localparam logic [15:0] OFS_IVEC  = 16'd2;

  // IMASK layout: bit7 global enable, bits[3:0] per-source enables.
  localparam int unsigned GIE_BIT     = 7;
  localparam logic [7:0]  IMASK_WMASK = 8'h8F;

  // Vectors are two words apart, starting at the source-0 vector.
  function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                           input logic [1:0]  idx);
    return base + {13'b0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// Four-input fixed-priority encoder: the lowest set request bit wins.
module prio_enc4 (
  input  logic [3:0] i_req,
  output logic       o_valid,
  output logic [1:0] o_idx
);

  // Scan from the highest index down so the lowest set bit is written last.
  always_comb begin
    o_valid = |i_req;
    o_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = i[1:0];
      end
    end
  end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller for the AVR soft core I/O space. Peripheral event
// pulses are captured into pending bits, masked, and presented to the CPU
// one at a time through an irq/ack/reti handshake. IMASK, IPEND and IVEC
// are readable on the port bus; the read data is zero for other addresses
// so it can be OR-ed with the existing peripheral read mux.
module irq_ctl
  import irq_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'h0024,
  parameter logic [15:0] VEC_BASE = 16'h0002
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] a,
  input  logic [7:0]  o,
  input  logic        w,
  input  logic        r,
  output logic [7:0]  p,
  input  logic [3:0]  ev,
  output logic        irq,
  output logic [15:0] irq_vec,
  input  logic        irq_ack,
  input  logic        reti
);

  // Architectural registers.
  logic [7:0]  r_imask;
  logic [3:0]  r_pend;
  state_t      r_state;
  logic [1:0]  r_idx;
  logic        r_in_svc;
  logic        r_irq;
  logic [15:0] r_irq_vec;

  // Address decode and write strobes.
  logic        w_sel_imask;
  logic        w_sel_ipend;
  logic        w_sel_ivec;
  logic        w_wr_imask;
  logic        w_wr_ipend;

  // Arbitration.
  logic        w_gie;
  logic [3:0]  w_cand;
  logic        w_cand_valid;
  logic [1:0]  w_cand_idx;
  logic        w_req_live;

  // Next-state values.
  state_t      w_state_next;
  logic [1:0]  w_idx_next;
  logic        w_in_svc_next;
  logic        w_irq_next;
  logic [15:0] w_irq_vec_next;
  logic [3:0]  w_ack_clr;
  logic [3:0]  w_sw_clr;
  logic [3:0]  w_pend_next;
  logic [7:0]  w_ivec;

  // Reads have no side effects, so the read strobe and the unimplemented
  // IMASK data bits are deliberately not consumed.
  logic        w_unused;
  assign w_unused = &{1'b0, r, o[6:4]};

  assign w_sel_imask = (a == BASE + OFS_IMASK);
  assign w_sel_ipend = (a == BASE + OFS_IPEND);
  assign w_sel_ivec  = (a == BASE + OFS_IVEC);
  assign w_wr_imask  = w & w_sel_imask;
  assign w_wr_ipend  = w & w_sel_ipend;

  // Candidates ignore pending bits whose source or global enable is off.
  assign w_gie  = r_imask[GIE_BIT];
  assign w_cand = r_pend & r_imask[3:0] & {NUM_SRC{w_gie}};

  prio_enc4 u_prio (
    .i_req   (w_cand),
    .o_valid (w_cand_valid),
    .o_idx   (w_cand_idx)
  );

  // The outstanding request stays valid only while its pend bit, its enable
  // and GIE are all still set.
  assign w_req_live = r_pend[r_idx] & r_imask[r_idx] & w_gie;

  // Software clear (write-one-to-clear) and the clear from an accepted ack.
  assign w_sw_clr  = w_wr_ipend ? o[3:0] : 4'b0000;
  assign w_ack_clr = ((r_state == S_REQ) && irq_ack) ? (4'b0001 << r_idx) : 4'b0000;

  // Per-source capture: a new event always wins over a clear in the same cycle.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
    assign w_pend_next[gi] = ev[gi] | (r_pend[gi] & ~w_sw_clr[gi] & ~w_ack_clr[gi]);
  end

  // Mask and pending register update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_imask <= 8'h00;
      r_pend  <= 4'h0;
    end else begin
      r_pend <= w_pend_next;
      if (w_wr_imask) begin
        r_imask <= o & IMASK_WMASK;
      end
    end
  end

  // FSM state register together with the registered handshake outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_idx     <= 2'd0;
      r_in_svc  <= 1'b0;
      r_irq     <= 1'b0;
      r_irq_vec <= VEC_BASE;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_in_svc  <= w_in_svc_next;
      r_irq     <= w_irq_next;
      r_irq_vec <= w_irq_vec_next;
    end
  end

  // FSM next-state logic; an ack in REQ takes precedence over withdrawal.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cand_valid) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          w_state_next = S_SVC;
        end else if (!w_req_live) begin
          w_state_next = S_IDLE;
        end
      end
      S_SVC: begin
        if (reti) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM outputs: latch the winner and its vector only when leaving IDLE.
  always_comb begin
    w_idx_next     = r_idx;
    w_irq_vec_next = r_irq_vec;
    w_irq_next     = (w_state_next == S_REQ);
    w_in_svc_next  = (w_state_next == S_SVC);
    if ((r_state == S_IDLE) && w_cand_valid) begin
      w_idx_next     = w_cand_idx;
      w_irq_vec_next = vec_addr(VEC_BASE, w_cand_idx);
    end
  end

  assign w_ivec = {r_in_svc, 1'b0, r_state, 2'b00, r_idx};

  // Port read mux; zero outside this block's three addresses.
  always_comb begin
    p = 8'h00;
    if (w_sel_imask) begin
      p = r_imask;
    end else if (w_sel_ipend) begin
      p = {4'b0000, r_pend};
    end else if (w_sel_ivec) begin
      p = w_ivec;
    end
  end

  assign irq     = r_irq;
  assign irq_vec = r_irq_vec;

endmodule
